// File: rtl/hmac_pkg.sv
// Shared constants, FSM state encoding and length-field helper for the HMAC message padder.
package hmac_pkg;

  localparam int BLOCK_BITS      = 512;
  localparam int DIGEST_BITS     = 256;
  localparam int LEN_FIELD_BITS  = 64;
  localparam int IPAD_BLOCK_BITS = 512;
  localparam int COUNT_BITS      = 7;

  typedef enum logic [2:0] {
    ST_COLLECT = 3'd0,
    ST_PAD     = 3'd1,
    ST_RUN     = 3'd2,
    ST_DONE    = 3'd3,
    ST_DRAIN   = 3'd4
  } pad_state_e;

  // Bit count of the hashed stream: the prepended ipad block plus the message bytes.
  function automatic logic [LEN_FIELD_BITS-1:0] len_field(input logic [COUNT_BITS-1:0] nbytes,
                                                          input int unsigned offset_bits);
    return LEN_FIELD_BITS'(offset_bits) + {54'd0, nbytes, 3'd0};
  endfunction

endpackage

// File: rtl/hmac_msg_padder_if.sv
// Byte stream in, padded block / core handshake, and HMAC result out, grouped as one bus.
interface hmac_msg_padder_if;
  import hmac_pkg::*;

  logic                   in_valid;
  logic [7:0]             in_data;
  logic                   in_last;
  logic                   in_ready;
  logic [BLOCK_BITS-1:0]  blk_data;
  logic                   core_go;
  logic                   core_data_available;
  logic [DIGEST_BITS-1:0] core_hmac;
  logic                   out_valid;
  logic [DIGEST_BITS-1:0] out_hmac;
  logic                   out_ready;
  logic                   err_overflow;

  modport slave (
    input  in_valid, in_data, in_last, core_data_available, core_hmac, out_ready,
    output in_ready, blk_data, core_go, out_valid, out_hmac, err_overflow
  );

  modport master (
    output in_valid, in_data, in_last, core_data_available, core_hmac, out_ready,
    input  in_ready, blk_data, core_go, out_valid, out_hmac, err_overflow
  );

endinterface

// File: rtl/hmac_pad_block.sv
// Combinational SHA-256 padding of a short message into one block: 0x80 marker,
// zero fill, and a 64-bit big-endian length that includes the ipad block.
module hmac_pad_block
  import hmac_pkg::*;
#(
  parameter int MAX_BYTES       = 55,
  parameter int LEN_OFFSET_BITS = IPAD_BLOCK_BITS
) (
  input  logic [8*MAX_BYTES-1:0] msg_i,
  input  logic [COUNT_BITS-1:0]  count_i,
  output logic [BLOCK_BITS-1:0]  blk_o
);

  // Keep bytes below the count, mark the first free byte, zero the rest, append length.
  always_comb begin
    blk_o = '0;
    for (int k = 0; k < MAX_BYTES; k++) begin
      if (COUNT_BITS'(k) < count_i) begin
        blk_o[BLOCK_BITS-1-8*k -: 8] = msg_i[8*MAX_BYTES-1-8*k -: 8];
      end else if (COUNT_BITS'(k) == count_i) begin
        blk_o[BLOCK_BITS-1-8*k -: 8] = 8'h80;
      end else begin
        blk_o[BLOCK_BITS-1-8*k -: 8] = 8'h00;
      end
    end
    if (count_i == COUNT_BITS'(MAX_BYTES)) begin
      blk_o[BLOCK_BITS-1-8*MAX_BYTES -: 8] = 8'h80;
    end else begin
      blk_o[BLOCK_BITS-1-8*MAX_BYTES -: 8] = 8'h00;
    end
    blk_o[LEN_FIELD_BITS-1:0] = len_field(count_i, LEN_OFFSET_BITS);
  end

endmodule

// File: rtl/hmac_msg_padder.sv
// Front end for hmac_sha256: collects a message byte stream, builds the padded inner block,
// runs the core once and holds the resulting HMAC on a valid/ready output.
module hmac_msg_padder
  import hmac_pkg::*;
#(
  parameter int MAX_BYTES       = 55,
  parameter int LEN_OFFSET_BITS = IPAD_BLOCK_BITS
) (
  input  logic               CLK,
  input  logic               RST,
  hmac_msg_padder_if.slave   bus
);

  pad_state_e             state_q, state_d;
  logic [COUNT_BITS-1:0]  count_q, count_d;
  logic [BLOCK_BITS-1:0]  blk_q, blk_d;
  logic [DIGEST_BITS-1:0] hmac_q, hmac_d;
  logic                   go_q, go_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic                   rdy_q, rdy_d;
  logic                   accept_s;
  logic [BLOCK_BITS-1:0]  pad_blk_s;

  assign accept_s = bus.in_valid & rdy_q;

  hmac_pad_block #(
    .MAX_BYTES       (MAX_BYTES),
    .LEN_OFFSET_BITS (LEN_OFFSET_BITS)
  ) u_pad (
    .msg_i   (blk_q[BLOCK_BITS-1 -: 8*MAX_BYTES]),
    .count_i (count_q),
    .blk_o   (pad_blk_s)
  );

  // Next-state and next-output logic; every registered output follows state_d.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    blk_d   = blk_q;
    hmac_d  = hmac_q;
    err_d   = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        if (accept_s) begin
          // A full buffer plus one more byte is an overflow; a final byte here drops it at once.
          if (count_q == COUNT_BITS'(MAX_BYTES)) begin
            if (bus.in_last) begin
              err_d   = 1'b1;
              count_d = '0;
              blk_d   = '0;
            end else begin
              state_d = ST_DRAIN;
            end
          end else begin
            for (int k = 0; k < MAX_BYTES; k++) begin
              if (count_q == COUNT_BITS'(k)) begin
                blk_d[BLOCK_BITS-1-8*k -: 8] = bus.in_data;
              end else begin
                blk_d[BLOCK_BITS-1-8*k -: 8] = blk_q[BLOCK_BITS-1-8*k -: 8];
              end
            end
            count_d = count_q + COUNT_BITS'(1);
            if (bus.in_last) begin
              state_d = ST_PAD;
            end else begin
              state_d = ST_COLLECT;
            end
          end
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_PAD: begin
        blk_d   = pad_blk_s;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.core_data_available) begin
          hmac_d  = bus.core_hmac;
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          count_d = '0;
          blk_d   = '0;
          state_d = ST_COLLECT;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DRAIN: begin
        if (accept_s && bus.in_last) begin
          err_d   = 1'b1;
          count_d = '0;
          blk_d   = '0;
          state_d = ST_COLLECT;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        count_d = '0;
        blk_d   = '0;
        state_d = ST_COLLECT;
      end
    endcase
    go_d    = (state_d == ST_RUN);
    valid_d = (state_d == ST_DONE);
    rdy_d   = (state_d == ST_COLLECT) || (state_d == ST_DRAIN);
  end

  // State and output registers; in_ready stays low until the first edge after reset release.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_COLLECT;
      count_q <= '0;
      blk_q   <= '0;
      hmac_q  <= '0;
      go_q    <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      blk_q   <= blk_d;
      hmac_q  <= hmac_d;
      go_q    <= go_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  assign bus.in_ready     = rdy_q;
  assign bus.blk_data     = blk_q;
  assign bus.core_go      = go_q;
  assign bus.out_valid    = valid_q;
  assign bus.out_hmac     = hmac_q;
  assign bus.err_overflow = err_q;

endmodule

// File: tb/tb_hmac_msg_padder.sv
// Directed bench for hmac_msg_padder: hand-computed padded blocks, core handshake,
// overflow drop, result back-pressure and mid-run reset.
module tb_hmac_msg_padder;
  import hmac_pkg::*;

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_errors = 0;
  int err_seen = 0;
  int go_seen = 0;

  always #5 clk = ~clk;

  hmac_msg_padder_if bus();

  hmac_msg_padder #(.MAX_BYTES(55), .LEN_OFFSET_BITS(512)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  always @(negedge clk) begin
    if (bus.err_overflow === 1'b1) err_seen <= err_seen + 1;
    if (bus.core_go === 1'b1) go_seen <= go_seen + 1;
  end

  task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) check_val("in_ready_timeout", 512'(bus.in_ready), 512'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_msg(input byte_q_t m);
    for (int i = 0; i < m.size(); i++) send_byte(m[i], (i == m.size() - 1));
  endtask

  task automatic run_msg(input string tag, input byte_q_t m, input logic [511:0] exp_blk,
                         input logic [255:0] h, input int stall);
    send_msg(m);
    check_val({tag, "_pad_go"}, 512'(bus.core_go), 512'd0);
    check_val({tag, "_pad_ready"}, 512'(bus.in_ready), 512'd0);
    @(negedge clk);
    check_val({tag, "_run_go"}, 512'(bus.core_go), 512'd1);
    check_val({tag, "_blk"}, bus.blk_data, exp_blk);
    @(negedge clk);
    @(negedge clk);
    check_val({tag, "_run_hold_go"}, 512'(bus.core_go), 512'd1);
    check_val({tag, "_run_hold_blk"}, bus.blk_data, exp_blk);
    bus.core_hmac = h;
    bus.core_data_available = 1'b1;
    @(negedge clk);
    bus.core_data_available = 1'b0;
    bus.core_hmac = ~h;
    check_val({tag, "_done_valid"}, 512'(bus.out_valid), 512'd1);
    check_val({tag, "_done_hmac"}, 512'(bus.out_hmac), 512'(h));
    check_val({tag, "_done_go"}, 512'(bus.core_go), 512'd0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_val({tag, "_stall_valid"}, 512'(bus.out_valid), 512'd1);
      check_val({tag, "_stall_hmac"}, 512'(bus.out_hmac), 512'(h));
      check_val({tag, "_stall_ready"}, 512'(bus.in_ready), 512'd0);
      check_val({tag, "_stall_go"}, 512'(bus.core_go), 512'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_val({tag, "_ack_valid"}, 512'(bus.out_valid), 512'd0);
    check_val({tag, "_ack_ready"}, 512'(bus.in_ready), 512'd1);
    check_val({tag, "_ack_blk"}, bus.blk_data, 512'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    byte_q_t m;
    logic [511:0] blk_abc;
    logic [511:0] blk_hi;
    logic [511:0] blk_55;
    int e0;
    int g0;

    blk_abc = {32'h61626380, 416'h0, 64'h218};
    blk_hi  = {64'h4869205468657265, 8'h80, 376'h0, 64'h240};
    blk_55  = {{55{8'hAA}}, 8'h80, 64'h3B8};

    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.in_last = 1'b0;
    bus.core_data_available = 1'b0;
    bus.core_hmac = '0;
    bus.out_ready = 1'b0;

    #3;
    check_val("rst_blk", bus.blk_data, 512'd0);
    check_val("rst_go", 512'(bus.core_go), 512'd0);
    check_val("rst_valid", 512'(bus.out_valid), 512'd0);
    check_val("rst_hmac", 512'(bus.out_hmac), 512'd0);
    check_val("rst_err", 512'(bus.err_overflow), 512'd0);
    check_val("rst_ready", 512'(bus.in_ready), 512'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("post_rst_ready", 512'(bus.in_ready), 512'd1);

    // data_available outside RUN must not produce a result
    bus.core_hmac = {8{32'hDEADBEEF}};
    bus.core_data_available = 1'b1;
    @(negedge clk);
    bus.core_data_available = 1'b0;
    @(negedge clk);
    check_val("stray_da_valid", 512'(bus.out_valid), 512'd0);
    check_val("stray_da_ready", 512'(bus.in_ready), 512'd1);

    m = '{8'h61, 8'h62, 8'h63};
    run_msg("abc", m, blk_abc, {8{32'h01234567}}, 0);

    m = '{8'h48, 8'h69, 8'h20, 8'h54, 8'h68, 8'h65, 8'h72, 8'h65};
    run_msg("hi", m, blk_hi, {8{32'h89ABCDEF}}, 10);

    m = {};
    for (int i = 0; i < 55; i++) m.push_back(8'hAA);
    e0 = err_seen;
    run_msg("max55", m, blk_55, {8{32'h55AA55AA}}, 1);
    check_val("max55_no_err", 512'(err_seen - e0), 512'd0);

    // 56 bytes: one byte too many, dropped on its final byte
    m = {};
    for (int i = 0; i < 56; i++) m.push_back(8'h11);
    e0 = err_seen;
    g0 = go_seen;
    send_msg(m);
    repeat (4) @(negedge clk);
    check_val("ovf56_err_once", 512'(err_seen - e0), 512'd1);
    check_val("ovf56_no_go", 512'(go_seen - g0), 512'd0);
    check_val("ovf56_ready", 512'(bus.in_ready), 512'd1);
    check_val("ovf56_blk", bus.blk_data, 512'd0);

    // 60 bytes: extra bytes are drained until the final one
    m = {};
    for (int i = 0; i < 60; i++) m.push_back(8'h22);
    e0 = err_seen;
    g0 = go_seen;
    send_msg(m);
    repeat (4) @(negedge clk);
    check_val("ovf60_err_once", 512'(err_seen - e0), 512'd1);
    check_val("ovf60_no_go", 512'(go_seen - g0), 512'd0);
    check_val("ovf60_ready", 512'(bus.in_ready), 512'd1);

    m = '{8'h61, 8'h62, 8'h63};
    run_msg("abc_after_ovf", m, blk_abc, {8{32'hCAFEF00D}}, 0);

    // asynchronous reset while the core is running
    send_msg(m);
    @(negedge clk);
    check_val("rr_go_before", 512'(bus.core_go), 512'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rr_go", 512'(bus.core_go), 512'd0);
    check_val("rr_blk", bus.blk_data, 512'd0);
    check_val("rr_valid", 512'(bus.out_valid), 512'd0);
    check_val("rr_ready", 512'(bus.in_ready), 512'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("rr_post_ready", 512'(bus.in_ready), 512'd1);
    run_msg("abc_after_rst", m, blk_abc, {8{32'h0BADC0DE}}, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
